// File: rtl/mem_arb_pkg.sv
// Shared command codes, FSM state encoding and command helper for mem_arbiter.
package mem_arb_pkg;

  localparam logic [2:0] CMD_WRITE = 3'd2;
  localparam logic [2:0] CMD_READ  = 3'd3;
  localparam logic [2:0] CMD_IDLE  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESP
  } state_e;

  // Unknown requester commands are still granted but reach memory as idle.
  function automatic logic [2:0] to_mem_cmd(input logic [2:0] cmd);
    return (cmd == CMD_WRITE || cmd == CMD_READ) ? cmd : CMD_IDLE;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin winner selection: on a tie the requester not granted last wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner,
  output logic any
);

  assign any    = req0 | req1;
  assign winner = (req0 && req1) ? ~last : req1;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter (IDLE -> ISSUE -> RESP).
// Optional burst lock: define MEM_ARB_BURST_LOCK_EN to let an owner keep the port for up to BURST_MAX accesses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 8,
  parameter int BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [2:0]    cmd0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic [2:0]    cmd1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [2:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  if (BURST_MAX < 1) begin : g_cfg_check
    $error("mem_arbiter: BURST_MAX must be at least 1");
  end

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          is_rd_q, is_rd_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic [2:0]    mem_cmd_q, mem_cmd_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic          pick_winner, pick_any;
  logic          load, load_owner;
  logic [2:0]    sel_cmd;

  rr_pick2 u_pick (
    .req0   (req0),
    .req1   (req1),
    .last   (last_q),
    .winner (pick_winner),
    .any    (pick_any)
  );

`ifdef MEM_ARB_BURST_LOCK_EN
  localparam int CW = $clog2(BURST_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_req;
  assign owner_req = owner_q ? req1 : req0;
`endif

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    is_rd_d     = is_rd_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    mem_cmd_d   = CMD_IDLE;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    load        = 1'b0;
    load_owner  = pick_winner;
    sel_cmd     = CMD_IDLE;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          load    = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        last_d  = owner_q;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
`ifdef MEM_ARB_BURST_LOCK_EN
        if (owner_req && (cnt_q < CW'(BURST_MAX))) begin
          load       = 1'b1;
          load_owner = owner_q;
          state_d    = ST_ISSUE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // Capture the winner's request so the memory command is driven from flops in ISSUE.
    if (load) begin
      sel_cmd     = load_owner ? cmd1 : cmd0;
      owner_d     = load_owner;
      is_rd_d     = (sel_cmd == CMD_READ);
      gnt0_d      = ~load_owner;
      gnt1_d      = load_owner;
      mem_cmd_d   = to_mem_cmd(sel_cmd);
      mem_addr_d  = load_owner ? addr1 : addr0;
      mem_wdata_d = load_owner ? wdata1 : wdata0;
    end
  end

`ifdef MEM_ARB_BURST_LOCK_EN
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) cnt_d = '0;
    if (load) cnt_d = (state_q == ST_RESP) ? cnt_q + CW'(1) : CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`endif

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      is_rd_q     <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      mem_cmd_q   <= CMD_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      is_rd_q     <= is_rd_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      mem_cmd_q   <= mem_cmd_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign mem_cmd   = mem_cmd_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rvalid0   = (state_q == ST_RESP) && is_rd_q && !owner_q;
  assign rvalid1   = (state_q == ST_RESP) && is_rd_q &&  owner_q;
  assign rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a simple one-cycle-latency memory model.
module tb_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1;
  logic [2:0]    cmd0, cmd1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic [2:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] mem [256];

  int checks = 0;
  int errors = 0;
  int grants[$];
  int exp_grants[$];

  always #5 clk = ~clk;

  mem_arbiter #(.DW(DW), .AW(AW), .BURST_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .cmd0      (cmd0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .req1      (req1),
    .cmd1      (cmd1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata     (rdata),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_cmd == 3'd2) mem[mem_addr] <= mem_wdata;
    if (mem_cmd == 3'd3) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_reqs();
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[255] = 32'h0000_1234;

    rst = 1'b0;
    req0 = 0; cmd0 = 3'd4; addr0 = '0; wdata0 = '0;
    req1 = 0; cmd1 = 3'd4; addr1 = '0; wdata1 = '0;
    #12;
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_rvalid0", rvalid0, 0);
    check("rst_rvalid1", rvalid1, 0);
    check("rst_mem_cmd", mem_cmd, 4);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    tick();
    rst = 1'b1;
    tick();
    check("idle_mem_cmd", mem_cmd, 4);

    // Single read from requester 0 at the top address.
    req0 = 1; cmd0 = 3'd3; addr0 = 8'd255;
    tick();
    check("rd_gnt0", gnt0, 1);
    check("rd_gnt1", gnt1, 0);
    check("rd_mem_cmd", mem_cmd, 3);
    check("rd_mem_addr", mem_addr, 255);
    req0 = 0;
    tick();
    check("rd_rvalid0", rvalid0, 1);
    check("rd_rvalid1", rvalid1, 0);
    check("rd_rdata", rdata, 32'h0000_1234);
    check("rd_resp_gnt0", gnt0, 0);
    check("rd_resp_cmd", mem_cmd, 4);
    tick();
    check("rd_idle_rvalid0", rvalid0, 0);

    // Write from requester 1, then read it back through requester 0.
    req1 = 1; cmd1 = 3'd2; addr1 = 8'd1; wdata1 = 32'd255;
    tick();
    check("wr_gnt1", gnt1, 1);
    check("wr_gnt0", gnt0, 0);
    check("wr_mem_cmd", mem_cmd, 2);
    check("wr_mem_addr", mem_addr, 1);
    check("wr_mem_wdata", mem_wdata, 255);
    req1 = 0;
    tick();
    check("wr_resp_cmd", mem_cmd, 4);
    check("wr_rvalid1", rvalid1, 0);
    check("wr_rvalid0", rvalid0, 0);
    tick();
    req0 = 1; cmd0 = 3'd3; addr0 = 8'd1;
    tick();
    check("rb_gnt0", gnt0, 1);
    req0 = 0;
    tick();
    check("rb_rvalid0", rvalid0, 1);
    check("rb_rdata", rdata, 255);
    tick();

    // Unsupported command is granted but never reaches memory.
    req0 = 1; cmd0 = 3'd5; addr0 = 8'd9;
    tick();
    check("bad_gnt0", gnt0, 1);
    check("bad_mem_cmd", mem_cmd, 4);
    req0 = 0;
    tick();
    check("bad_rvalid0", rvalid0, 0);
    check("bad_resp_cmd", mem_cmd, 4);
    tick();

    // Both requesters held from reset: grant order and mutual exclusion.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    req0 = 1; cmd0 = 3'd3; addr0 = 8'd10;
    req1 = 1; cmd1 = 3'd3; addr1 = 8'd20;
    for (int c = 1; c <= 11; c++) begin
      tick();
      check("dual_gnt", gnt0 & gnt1, 0);
      check("dual_rvalid", rvalid0 & rvalid1, 0);
      if (gnt0) begin
        grants.push_back(0);
        check("rr_addr0", mem_addr, 10);
      end
      if (gnt1) begin
        grants.push_back(1);
        check("rr_addr1", mem_addr, 20);
      end
      if (c == 10) drop_reqs();
    end
`ifdef MEM_ARB_BURST_LOCK_EN
    exp_grants = '{0, 0, 0, 0, 1};
`else
    exp_grants = '{0, 1, 0, 1};
`endif
    check("rr_grant_count", grants.size(), exp_grants.size());
    for (int i = 0; i < exp_grants.size() && i < grants.size(); i++)
      check($sformatf("rr_grant_%0d", i), grants[i], exp_grants[i]);
    tick();
    tick();

    // Reset in the middle of an ISSUE aborts the read and restores the tie pointer.
    req0 = 1; cmd0 = 3'd3; addr0 = 8'd7;
    tick();
    req0 = 0;
    tick();
    tick();
    req0 = 1; cmd0 = 3'd3; addr0 = 8'd255;
    tick();
    check("abort_gnt0_pre", gnt0, 1);
    rst = 1'b0;
    #1;
    check("abort_gnt0", gnt0, 0);
    check("abort_mem_cmd", mem_cmd, 4);
    check("abort_mem_addr", mem_addr, 0);
    check("abort_mem_wdata", mem_wdata, 0);
    check("abort_rvalid0", rvalid0, 0);
    req0 = 0;
    #1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("abort_no_rvalid0", rvalid0, 0);
      check("abort_no_rvalid1", rvalid1, 0);
    end
    req0 = 1; cmd0 = 3'd3; addr0 = 8'd3;
    req1 = 1; cmd1 = 3'd3; addr1 = 8'd4;
    tick();
    check("post_rst_tie_gnt0", gnt0, 1);
    check("post_rst_tie_gnt1", gnt1, 0);
    drop_reqs();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
